arrow_judge: RTL and testbench

Consumer end of the arrow stream. It latches one code from the random arrow generator (`random_arrow`, codes 10–20), shows it on one seven-segment digit, and judges the player's four direction buttons within a tick-timed window. It keeps score and miss count, and asserts `game_over` when the miss limit is reached. It sits between the random generator, the button debouncers and the display mux, and is driven by the same game `state` bus.

---
 rtl/arrow_judge.sv | 174 +++++++++++++++++
 tb/tb_arrow_judge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_judge.sv
// arrow_judge: latches one arrow code, shows it on a seven-segment digit and
// judges the player's direction buttons within a tick-timed response window.
// Tracks a saturating score and a miss count; game_over ends the round.
module arrow_judge #(
  parameter int WINDOW_TICKS = 4,
  parameter int GAP_TICKS    = 1,
  parameter int MAX_MISSES   = 3,
  parameter int SCORE_MAX    = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic [4:0] random_arrow,
  input  logic [3:0] btn,
  input  logic       tick,
  output logic [6:0] arrow_seg,
  output logic [6:0] score,
  output logic [1:0] misses,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} fsm_t;

  localparam logic [1:0] ST_GAME  = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd2;

  localparam int TCNT_W = 8;
  localparam logic [TCNT_W-1:0] WIN_LAST  = TCNT_W'(WINDOW_TICKS - 1);
  localparam logic [TCNT_W-1:0] GAP_MIN   = TCNT_W'(GAP_TICKS);
  localparam logic [6:0]        SCORE_SAT = 7'(SCORE_MAX);
  localparam logic [1:0]        MISS_LIM  = 2'(MAX_MISSES);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_UP    = 7'b1111110;
  localparam logic [6:0] SEG_DOWN  = 7'b1110111;
  localparam logic [6:0] SEG_LEFT  = 7'b1001111;
  localparam logic [6:0] SEG_RIGHT = 7'b1111001;

  fsm_t              fsm;
  logic [4:0]        cur;
  logic [3:0]        acc;
  logic [TCNT_W-1:0] tcnt;

  logic [3:0] mask;
  logic [3:0] acc_next;
  logic       judge_hit;
  logic       judge_miss;
  logic [1:0] misses_inc;
  logic [6:0] score_inc;

  // Required button mask {U,D,L,R}; codes outside 10..19 mean "press nothing".
  function automatic logic [3:0] code_mask(input logic [4:0] code);
    case (code)
      5'd10:   code_mask = 4'b1000;
      5'd11:   code_mask = 4'b0100;
      5'd12:   code_mask = 4'b0010;
      5'd13:   code_mask = 4'b0001;
      5'd14:   code_mask = 4'b1100;
      5'd15:   code_mask = 4'b1010;
      5'd16:   code_mask = 4'b1001;
      5'd17:   code_mask = 4'b0110;
      5'd18:   code_mask = 4'b0101;
      5'd19:   code_mask = 4'b0011;
      default: code_mask = 4'b0000;
    endcase
  endfunction

  // Active-low segment pattern; combos light the union of both arrows.
  function automatic logic [6:0] code_seg(input logic [4:0] code);
    case (code)
      5'd10:   code_seg = SEG_UP;
      5'd11:   code_seg = SEG_DOWN;
      5'd12:   code_seg = SEG_LEFT;
      5'd13:   code_seg = SEG_RIGHT;
      5'd14:   code_seg = SEG_UP   & SEG_DOWN;
      5'd15:   code_seg = SEG_UP   & SEG_LEFT;
      5'd16:   code_seg = SEG_UP   & SEG_RIGHT;
      5'd17:   code_seg = SEG_DOWN & SEG_LEFT;
      5'd18:   code_seg = SEG_DOWN & SEG_RIGHT;
      5'd19:   code_seg = SEG_LEFT & SEG_RIGHT;
      default: code_seg = SEG_BLANK;
    endcase
  endfunction

  // Judgment for the current SHOW cycle: wrong press beats completion beats timeout.
  always_comb begin
    mask       = code_mask(cur);
    acc_next   = acc | btn;
    judge_hit  = 1'b0;
    judge_miss = 1'b0;
    if ((acc_next & ~mask) != 4'b0000) begin
      judge_miss = 1'b1;
    end else if ((mask != 4'b0000) && (acc_next == mask)) begin
      judge_hit = 1'b1;
    end else if (tick && (tcnt == WIN_LAST)) begin
      if ((mask == 4'b0000) && (acc_next == 4'b0000)) judge_hit = 1'b1;
      else                                            judge_miss = 1'b1;
    end
    misses_inc = misses + 2'd1;
    score_inc  = (score >= SCORE_SAT) ? SCORE_SAT : score + 7'd1;
  end

  // Game FSM with registered display, counters and pulses.
  always_ff @(posedge clk) begin
    if (!rst_n || state == ST_RESET) begin
      fsm        <= IDLE;
      cur        <= '0;
      acc        <= '0;
      tcnt       <= '0;
      arrow_seg  <= SEG_BLANK;
      score      <= '0;
      misses     <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (state == ST_GAME) begin
        case (fsm)
          IDLE: begin
            fsm       <= SHOW;
            cur       <= random_arrow;
            acc       <= '0;
            tcnt      <= '0;
            arrow_seg <= code_seg(random_arrow);
          end
          SHOW: begin
            acc <= acc_next;
            if (judge_hit) begin
              score     <= score_inc;
              hit_pulse <= 1'b1;
              arrow_seg <= SEG_BLANK;
              tcnt      <= '0;
              fsm       <= GAP;
            end else if (judge_miss) begin
              misses     <= misses_inc;
              miss_pulse <= 1'b1;
              arrow_seg  <= SEG_BLANK;
              tcnt       <= '0;
              if (misses_inc == MISS_LIM) begin
                fsm       <= OVER;
                game_over <= 1'b1;
              end else begin
                fsm <= GAP;
              end
            end else if (tick) begin
              tcnt <= tcnt + 1'b1;
            end
          end
          GAP: begin
            // tcnt saturates at GAP_MIN so a long button hold cannot wrap it.
            if (tcnt >= GAP_MIN && btn == 4'b0000) begin
              fsm       <= SHOW;
              cur       <= random_arrow;
              acc       <= '0;
              tcnt      <= '0;
              arrow_seg <= code_seg(random_arrow);
            end else if (tick && tcnt < GAP_MIN) begin
              tcnt <= tcnt + 1'b1;
            end
          end
          OVER: begin
            arrow_seg <= SEG_BLANK;
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arrow_judge.sv
// Scoreboard bench for arrow_judge: directed stimulus pushes the expected
// judgment; a negedge monitor pops it whenever a hit/miss pulse appears.
module tb_arrow_judge;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_UP    = 7'b1111110;
  localparam logic [6:0] SEG_DOWN  = 7'b1110111;
  localparam logic [6:0] SEG_DR    = 7'b1110001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state;
  logic [4:0] random_arrow;
  logic [3:0] btn;
  logic       tick;
  logic [6:0] arrow_seg;
  logic [6:0] score;
  logic [1:0] misses;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  typedef struct packed {
    logic       hit;
    logic [6:0] score;
    logic [1:0] misses;
    logic       go;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   m_score = 0;
  int   m_misses = 0;

  arrow_judge #(
    .WINDOW_TICKS(4),
    .GAP_TICKS   (1),
    .MAX_MISSES  (3),
    .SCORE_MAX   (99)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .random_arrow(random_arrow),
    .btn         (btn),
    .tick        (tick),
    .arrow_seg   (arrow_seg),
    .score       (score),
    .misses      (misses),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Monitor: every pulse must match the oldest expected judgment.
  always @(negedge clk) begin
    if (hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b score=%0d misses=%0d, required no pulse",
                 hit_pulse, miss_pulse, score, misses);
      end else begin
        mon_e = q.pop_front();
        if (hit_pulse !== mon_e.hit || miss_pulse !== !mon_e.hit || score !== mon_e.score ||
            misses !== mon_e.misses || game_over !== mon_e.go) begin
          fails++;
          $display("FAIL judgment: got hit=%0b miss=%0b score=%0d misses=%0d go=%0b, expected hit=%0b score=%0d misses=%0d go=%0b",
                   hit_pulse, miss_pulse, score, misses, game_over,
                   mon_e.hit, mon_e.score, mon_e.misses, mon_e.go);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_judge(input logic hit);
    exp_t e;
    if (hit) m_score = (m_score < 99) ? m_score + 1 : 99;
    else     m_misses++;
    e.hit    = hit;
    e.score  = 7'(m_score);
    e.misses = 2'(m_misses);
    e.go     = (m_misses == 3);
    q.push_back(e);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"},    32'(arrow_seg),  32'(SEG_BLANK));
    check({tag, "_score"},  32'(score),      32'd0);
    check({tag, "_misses"}, 32'(misses),     32'd0);
    check({tag, "_pulses"}, 32'({hit_pulse, miss_pulse}), 32'd0);
    check({tag, "_over"},   32'(game_over),  32'd0);
  endtask

  // Reset, then release with state=GAME so the next edge enters SHOW with code.
  task automatic do_reset(input logic [4:0] code);
    rst_n = 1'b0;
    state = 2'd0;
    btn = 4'b0000;
    tick = 1'b0;
    random_arrow = code;
    cyc(2);
    check_reset_outputs("rst");
    m_score = 0;
    m_misses = 0;
    rst_n = 1'b1;
    cyc();
  endtask

  // From GAP (tcnt=0): one tick satisfies the gap, then the next edge enters SHOW.
  task automatic gap_to_show(input logic [4:0] code);
    btn = 4'b0000;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    random_arrow = code;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    state = 2'd0;
    btn = 4'b0000;
    tick = 1'b0;
    random_arrow = 5'd10;

    // Single-direction hit
    do_reset(5'd10);
    check("up_seg", 32'(arrow_seg), 32'(SEG_UP));
    btn = 4'b1000;
    expect_judge(1'b1);
    cyc();
    check("gap_blank", 32'(arrow_seg), 32'(SEG_BLANK));
    check("score_1", 32'(score), 32'd1);

    // Two-direction staggered hit
    gap_to_show(5'd18);
    check("dr_seg", 32'(arrow_seg), 32'(SEG_DR));
    btn = 4'b0100;
    cyc(5);
    check("dr_pending_score", 32'(score), 32'd1);
    btn = 4'b0101;
    expect_judge(1'b1);
    cyc();
    btn = 4'b0000;

    // Wrong button three times ends the game
    for (int i = 0; i < 3; i++) begin
      gap_to_show(5'd12);
      btn = 4'b1000;
      expect_judge(1'b0);
      cyc();
      btn = 4'b0000;
    end
    check("over_flag", 32'(game_over), 32'd1);
    check("over_seg", 32'(arrow_seg), 32'(SEG_BLANK));
    btn = 4'b0001;
    tick_pulse();
    tick_pulse();
    btn = 4'b0000;
    random_arrow = 5'd13;
    cyc(3);
    check("over_score", 32'(score), 32'd2);
    check("over_misses", 32'(misses), 32'd3);
    check("over_seg_hold", 32'(arrow_seg), 32'(SEG_BLANK));

    // NONE arrow: silence for the full window is a hit on the 4th tick
    do_reset(5'd20);
    check("none_seg", 32'(arrow_seg), 32'(SEG_BLANK));
    tick_pulse();
    tick_pulse();
    tick_pulse();
    check("none_wait_score", 32'(score), 32'd0);
    expect_judge(1'b1);
    tick_pulse();

    // Out-of-range code behaves as NONE; any press misses
    gap_to_show(5'd5);
    check("oor_seg", 32'(arrow_seg), 32'(SEG_BLANK));
    btn = 4'b0010;
    expect_judge(1'b0);
    cyc();
    btn = 4'b0000;

    // Combo finished on the same edge as the final tick counts as a hit
    gap_to_show(5'd14);
    btn = 4'b1000;
    tick_pulse();
    tick_pulse();
    tick_pulse();
    btn = 4'b1100;
    tick = 1'b1;
    expect_judge(1'b1);
    cyc();
    tick = 1'b0;
    btn = 4'b0000;

    // Pause mid-window freezes tcnt and ignores buttons
    gap_to_show(5'd11);
    check("down_seg", 32'(arrow_seg), 32'(SEG_DOWN));
    tick_pulse();
    tick_pulse();
    state = 2'd1;
    btn = 4'b1000;
    for (int i = 0; i < 10; i++) tick_pulse();
    state = 2'd3;
    tick_pulse();
    btn = 4'b0000;
    check("pause_seg", 32'(arrow_seg), 32'(SEG_DOWN));
    check("pause_misses", 32'(misses), 32'd1);
    state = 2'd0;
    tick_pulse();
    check("resume_misses", 32'(misses), 32'd1);
    expect_judge(1'b0);
    tick_pulse();
    check("timeout_misses", 32'(misses), 32'd2);

    // Held button extends GAP until release
    btn = 4'b0001;
    tick_pulse();
    tick_pulse();
    random_arrow = 5'd10;
    cyc(3);
    check("held_gap_seg", 32'(arrow_seg), 32'(SEG_BLANK));
    btn = 4'b0000;
    cyc();
    check("release_show_seg", 32'(arrow_seg), 32'(SEG_UP));

    // RESET state mid-SHOW drops the pending hit
    state = 2'd2;
    btn = 4'b1000;
    cyc();
    check_reset_outputs("state_rst");
    m_score = 0;
    m_misses = 0;
    cyc(2);
    btn = 4'b0000;
    state = 2'd0;
    random_arrow = 5'd10;
    cyc();
    check("post_rst_seg", 32'(arrow_seg), 32'(SEG_UP));

    // Wrong plus correct press in one cycle is a miss
    btn = 4'b1001;
    expect_judge(1'b0);
    cyc();
    btn = 4'b0000;

    // Score saturation at 99
    for (int i = 0; i < 100; i++) begin
      gap_to_show(5'd13);
      btn = 4'b0001;
      expect_judge(1'b1);
      cyc();
      btn = 4'b0000;
    end
    check("score_sat", 32'(score), 32'd99);

    cyc(3);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
